i2c_target_sync: RTL and testbench
==================================

Name: i2c_target_sync

Overview:
- System-clock-synchronous I2C target (slave) with an 8-bit register-file interface.
- Responds to transactions from i2c_master.
- Oversamples SCL/SDA on clk, detects START/STOP/repeated-START properly, and drives SDA open-drain (low-only).
- Maps write bytes to register writes and read bytes to register reads through an auto-incrementing 8-bit pointer.

Parameters:
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (min 2).
- Requirement on clk: frequency >= 20x SCL frequency.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- scl_in  input  1  raw SCL from pad
- sda_in  input  1  raw SDA from pad
- sda_oe  output  1  1 = pull SDA low; 0 = release. Top level does: sda = sda_oe ? 0 : z
- slave_addr  input  7  own 7-bit address, static during transaction
- reg_addr  output  8  register pointer
- reg_wdata  output  8  write data, valid with reg_we
- reg_we  output  1  one-clk write strobe
- reg_re  output  1  one-clk read strobe; reg_rdata valid exactly 1 clk later
- reg_rdata  input  8  read data
- busy  output  1  high from START until STOP, NACKed read, or address mismatch

Behaviour:
- Reset (rst_n low at clk edge): sda_oe=0, reg_we=0, reg_re=0, reg_addr=0x00, reg_wdata=0x00, busy=0, state IDLE, bit counter 0. Reset mid-transaction aborts immediately and releases SDA on the next clk.
- Inputs: SYNC_STAGES-flop synchronizers plus one history flop. Edge events are derived from the synced signals:
  - SCL rise / SCL fall.
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
- Latency: SDA/SCL event reaches sda_oe within SYNC_STAGES+2 clk.
- Global rules, priority START/STOP > state logic:
  - START in any state, including repeated START: go to RX_ADDR, clear bit counter, busy=1, sda_oe=0.
  - STOP in any state: go to IDLE, busy=0, sda_oe=0.
  - A partially received byte is discarded: no reg_we.
- Sampling and driving:
  - Data bits are sampled on SCL rise, MSB first.
  - sda_oe changes only on SCL fall (plus the abort cases above).
- States:
  - IDLE: ignore bus except START.
  - RX_ADDR: shift 8 bits. On the 8th SCL rise compare bits[7:1] with slave_addr and latch rw = bit0.
    - Match: on next SCL fall assert sda_oe (ACK) and go to ACK_ADDR. If rw=1, pulse reg_re at the same time.
    - Mismatch: go to IDLE with busy=0; sda_oe stays 0.
  - ACK_ADDR: on next SCL fall:
    - rw=0: release SDA and go to RX_PTR.
    - rw=1: load shift register with captured reg_rdata, drive bit7 (sda_oe = ~bit), go to TX_BYTE.
  - RX_PTR: 8 bits. On 8th rise load reg_addr. ACK on fall (sda_oe=1 for one SCL period), then go to RX_DATA.
  - RX_DATA: 8 bits. On 8th rise:
    - reg_wdata = byte, reg_we pulses 1 clk with current reg_addr.
    - reg_addr increments 1 clk later, 8-bit wrap 0xFF->0x00.
    - ACK on SCL fall as above; stay in RX_DATA for further bytes.
  - TX_BYTE: shift out on each SCL fall. After the 8th bit's SCL fall, release SDA and go to WAIT_MACK.
  - WAIT_MACK: sample SDA on SCL rise.
    - 0 (ACK): increment reg_addr with wrap, pulse reg_re next clk, return to TX_BYTE (load on next SCL fall).
    - 1 (NACK): go to IDLE with busy=0, sda_oe=0; wait for STOP/START.
- The target never stretches SCL.
- reg_we and reg_re are never asserted together and are never asserted outside an addressed transaction.

Test Plan:
- Write: START, 0xA0 (addr 0x50, W), 0x10, 0xA5, 0x3C, STOP with slave_addr=0x50 -> target ACKs all 4 bytes (SDA low on each 9th SCL); reg_we at 0x10/0xA5 then 0x11/0x3C; reg_addr=0x12 after; busy falls at STOP.
- Read: write pointer 0x20, repeated START, 0xA1, read 2 bytes (master ACK then NACK); model reg_rdata = ~reg_addr -> SDA carries 0xDF then 0xDE; reg_re pulses at 0x20, 0x21; after NACK sda_oe=0, busy=0.
- Address mismatch: START, 0xA2 (0x51) -> sda_oe never 1, no reg_we/reg_re, busy=0 after 8th bit. A following 0xA0 transaction succeeds.
- Pointer wrap: pointer 0xFF, write 0x11, 0x22 -> reg_we at 0xFF/0x11, then 0x00/0x22.
- Abort: STOP after 3 bits of a data byte -> no reg_we, state IDLE. Repeated START mid-byte -> new address phase, correct ACK.
- Reset mid-read while sda_oe=1 -> sda_oe=0 next clk, all outputs at reset values; next transaction normal.

Source files
------------

// File: rtl/i2c_target_sync.sv
// I2C target on the system clock: oversampled SCL/SDA, open-drain SDA (low-only),
// bytes mapped onto an 8-bit register file through an auto-incrementing pointer.
module i2c_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] slave_addr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
  } bus_ev_t;

  typedef enum logic [3:0] {
    IDLE, RX_ADDR, ACK_ADDR, RX_PTR, RX_DATA, ACK_RX, TX_LOAD, TX_BYTE, WAIT_MACK
  } state_t;

  // [SS-1] is the synchronized level, [SS] the history flop used for edges
  logic [SS:0] scl_pipe, sda_pipe;
  logic        scl_s, scl_h, sda_s, sda_h;
  bus_ev_t     ev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
    end else begin
      scl_pipe <= {scl_pipe[SS-1:0], scl_in};
      sda_pipe <= {sda_pipe[SS-1:0], sda_in};
    end
  end

  assign scl_s = scl_pipe[SS-1];
  assign scl_h = scl_pipe[SS];
  assign sda_s = sda_pipe[SS-1];
  assign sda_h = sda_pipe[SS];

  always_comb begin
    ev          = '0;
    ev.scl_rise = scl_s & ~scl_h;
    ev.scl_fall = ~scl_s & scl_h;
    ev.start    = scl_s & scl_h & sda_h & ~sda_s;
    ev.stop     = scl_s & scl_h & ~sda_h & sda_s;
  end

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] rdata_q;
  logic       rw;
  logic       ack_pend;   // 8th bit of a byte taken, ACK goes out on the next SCL fall
  logic       re_pend;
  logic       re_d;
  logic       inc_pend;
  logic [7:0] rx_byte;
  logic       last_bit;

  assign rx_byte  = {shreg[6:0], sda_s};
  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rdata_q   <= '0;
      rw        <= 1'b0;
      ack_pend  <= 1'b0;
      re_pend   <= 1'b0;
      re_d      <= 1'b0;
      inc_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_d   <= reg_re;
      if (re_d) rdata_q <= reg_rdata;
      // post-write pointer bump lands one clk after the reg_we strobe
      if (inc_pend) begin
        reg_addr <= reg_addr + 8'd1;
        inc_pend <= 1'b0;
      end

      if (ev.start) begin
        state    <= RX_ADDR;
        bit_cnt  <= '0;
        busy     <= 1'b1;
        sda_oe   <= 1'b0;
        ack_pend <= 1'b0;
        re_pend  <= 1'b0;
      end else if (ev.stop) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        busy     <= 1'b0;
        sda_oe   <= 1'b0;
        ack_pend <= 1'b0;
        re_pend  <= 1'b0;
      end else begin
        if (re_pend) begin
          reg_re  <= 1'b1;
          re_pend <= 1'b0;
        end
        case (state)
          RX_ADDR, RX_PTR, RX_DATA: begin
            if (ev.scl_rise && !ack_pend) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                if (state == RX_ADDR) begin
                  if (rx_byte[7:1] == slave_addr) begin
                    rw       <= rx_byte[0];
                    ack_pend <= 1'b1;
                  end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                  end
                end else if (state == RX_PTR) begin
                  reg_addr <= rx_byte;
                  ack_pend <= 1'b1;
                end else begin
                  reg_wdata <= rx_byte;
                  reg_we    <= 1'b1;
                  inc_pend  <= 1'b1;
                  ack_pend  <= 1'b1;
                end
              end
            end else if (ev.scl_fall && ack_pend) begin
              ack_pend <= 1'b0;
              sda_oe   <= 1'b1;
              if (state == RX_ADDR) begin
                state  <= ACK_ADDR;
                reg_re <= rw;
              end else begin
                state <= ACK_RX;
              end
            end
          end
          ACK_ADDR: begin
            if (ev.scl_fall) begin
              bit_cnt <= '0;
              if (!rw) begin
                sda_oe <= 1'b0;
                state  <= RX_PTR;
              end else begin
                shreg  <= rdata_q;
                sda_oe <= ~rdata_q[7];
                state  <= TX_BYTE;
              end
            end
          end
          ACK_RX: begin
            if (ev.scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= RX_DATA;
            end
          end
          TX_LOAD: begin
            if (ev.scl_fall) begin
              shreg   <= rdata_q;
              sda_oe  <= ~rdata_q[7];
              bit_cnt <= '0;
              state   <= TX_BYTE;
            end
          end
          TX_BYTE: begin
            if (ev.scl_fall) begin
              if (last_bit) begin
                sda_oe <= 1'b0;
                state  <= WAIT_MACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          WAIT_MACK: begin
            if (ev.scl_rise) begin
              if (!sda_s) begin
                reg_addr <= reg_addr + 8'd1;
                re_pend  <= 1'b1;
                state    <= TX_LOAD;
              end else begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_sync.sv
// Directed bench: a bit-banged I2C master drives the target; register strobes are logged and checked.
module tb_i2c_target_sync;
  localparam int Q = 8;  // clks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [6:0] slave_addr = 7'h50;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  wire        sda_line = sda_m & ~sda_oe;

  int tests = 0;
  int fails = 0;

  logic [7:0] we_a[$], we_d[$], re_a[$];
  logic       oe_seen = 1'b0;
  int         both_cnt = 0;

  always #5 clk = ~clk;
  assign reg_rdata = ~reg_addr;

  i2c_target_sync #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .slave_addr(slave_addr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin we_a.push_back(reg_addr); we_d.push_back(reg_wdata); end
      if (reg_re) re_a.push_back(reg_addr);
      if (reg_we && reg_re) both_cnt++;
      if (sda_oe) oe_seen = 1'b1;
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clear_log();
    we_a.delete(); we_d.delete(); re_a.delete();
    oe_seen = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = ~sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      d[i] = sda_line; wait_q();
      scl_m = 1'b0; wait_q();
    end
    write_bit(~mack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({sda_oe, reg_we, reg_re, busy} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got oe/we/re/busy=%b want 0000", {sda_oe, reg_we, reg_re, busy});
    end
    tests++;
    if ({reg_addr, reg_wdata} !== 16'h0000) begin
      fails++; $display("FAIL reset_regs: got addr=%h wdata=%h want 00 00", reg_addr, reg_wdata);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    clear_log();
    i2c_start();
    write_byte(8'hA0, a0); write_byte(8'h10, a1); write_byte(8'hA5, a2); write_byte(8'h3C, a3);
    tests++;
    if ({a0, a1, a2, a3} !== 4'b1111) begin
      fails++; $display("FAIL write_acks: got %b want 1111", {a0, a1, a2, a3});
    end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL write_busy_mid: got %b want 1", busy); end
    i2c_stop();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_stop: got %b want 0", busy); end
    tests++;
    if (we_a.size() != 2 || {we_a[0], we_d[0], we_a[1], we_d[1]} !== 32'h10A5113C) begin
      fails++; $display("FAIL write_strobes: got n=%0d %h/%h %h/%h want 2 10/a5 11/3c",
                        we_a.size(), we_a[0], we_d[0], we_a[1], we_d[1]);
    end
    tests++;
    if (reg_addr !== 8'h12 || re_a.size() != 0) begin
      fails++; $display("FAIL write_ptr: got addr=%h re=%0d want 12 0", reg_addr, re_a.size());
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    clear_log();
    i2c_start(); write_byte(8'hA0, a0); write_byte(8'h20, a1);
    i2c_start(); write_byte(8'hA1, a2);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    tests++;
    if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
    tests++;
    if ({d0, d1} !== 16'hDFDE) begin fails++; $display("FAIL read_data: got %h %h want df de", d0, d1); end
    tests++;
    if (re_a.size() != 2 || {re_a[0], re_a[1]} !== 16'h2021) begin
      fails++; $display("FAIL read_strobes: got n=%0d %h %h want 2 20 21", re_a.size(), re_a[0], re_a[1]);
    end
    tests++;
    if ({sda_oe, busy} !== 2'b00 || we_a.size() != 0) begin
      fails++; $display("FAIL read_nack: got oe=%b busy=%b we=%0d want 0 0 0", sda_oe, busy, we_a.size());
    end
    i2c_stop();
  endtask

  task automatic test_mismatch();
    logic a0, a1, a2, a3;
    clear_log();
    i2c_start(); write_byte(8'hA2, a0);
    tests++;
    if ({a0, oe_seen, busy} !== 3'b000 || we_a.size() != 0 || re_a.size() != 0) begin
      fails++; $display("FAIL mismatch: got ack=%b oe=%b busy=%b we=%0d re=%0d want 0 0 0 0 0",
                        a0, oe_seen, busy, we_a.size(), re_a.size());
    end
    i2c_stop();
    i2c_start(); write_byte(8'hA0, a1); write_byte(8'h05, a2); write_byte(8'h66, a3); i2c_stop();
    tests++;
    if ({a1, a2, a3} !== 3'b111 || we_a.size() != 1 || {we_a[0], we_d[0]} !== 16'h0566) begin
      fails++; $display("FAIL mismatch_followup: got acks=%b n=%0d %h/%h want 111 1 05/66",
                        {a1, a2, a3}, we_a.size(), we_a[0], we_d[0]);
    end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    clear_log();
    i2c_start(); write_byte(8'hA0, a0); write_byte(8'hFF, a1); write_byte(8'h11, a2); write_byte(8'h22, a3);
    i2c_stop();
    tests++;
    if ({a0, a1, a2, a3} !== 4'b1111 || we_a.size() != 2 || {we_a[0], we_d[0], we_a[1], we_d[1]} !== 32'hFF110022) begin
      fails++; $display("FAIL wrap: got acks=%b n=%0d %h/%h %h/%h want 1111 2 ff/11 00/22",
                        {a0, a1, a2, a3}, we_a.size(), we_a[0], we_d[0], we_a[1], we_d[1]);
    end
    tests++;
    if (reg_addr !== 8'h01) begin fails++; $display("FAIL wrap_ptr: got %h want 01", reg_addr); end
  endtask

  task automatic test_abort();
    logic a0, a1, a2, a3, a4, a5;
    clear_log();
    i2c_start(); write_byte(8'hA0, a0); write_byte(8'h40, a1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    i2c_stop();
    tests++;
    if ({a0, a1} !== 2'b11 || we_a.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_stop: got acks=%b we=%0d busy=%b want 11 0 0", {a0, a1}, we_a.size(), busy);
    end
    i2c_start(); write_byte(8'hA0, a2); write_byte(8'h50, a3);
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    i2c_start(); write_byte(8'hA0, a4); write_byte(8'h60, a5);
    write_byte(8'h99, a0);
    i2c_stop();
    tests++;
    if ({a2, a3, a4, a5, a0} !== 5'b11111 || we_a.size() != 1 || {we_a[0], we_d[0]} !== 16'h6099) begin
      fails++; $display("FAIL abort_restart: got acks=%b n=%0d %h/%h want 11111 1 60/99",
                        {a2, a3, a4, a5, a0}, we_a.size(), we_a[0], we_d[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2, a3, a4;
    logic [7:0] b;
    bit got;
    clear_log();
    b = 8'hA1;
    i2c_start(); write_byte(8'hA0, a0); write_byte(8'h30, a1);
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (sda_oe) got = 1'b1;
    end
    tests++;
    if (!got) begin fails++; $display("FAIL rst_mid_ack: got sda_oe=0 within 40 clks want 1"); end
    scl_m = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({sda_oe, busy, reg_we, reg_re} !== 4'b0000 || {reg_addr, reg_wdata} !== 16'h0000) begin
      fails++; $display("FAIL rst_mid_state: got oe/busy/we/re=%b addr=%h wdata=%h want 0000 00 00",
                        {sda_oe, busy, reg_we, reg_re}, reg_addr, reg_wdata);
    end
    rst_n = 1'b1;
    wait_q();
    scl_m = 1'b0; wait_q();
    i2c_stop();
    clear_log();
    i2c_start(); write_byte(8'hA0, a2); write_byte(8'h07, a3); write_byte(8'h5A, a4); i2c_stop();
    tests++;
    if ({a2, a3, a4} !== 3'b111 || we_a.size() != 1 || {we_a[0], we_d[0], reg_addr} !== 24'h075A08) begin
      fails++; $display("FAIL rst_mid_after: got acks=%b n=%0d %h/%h addr=%h want 111 1 07/5a 08",
                        {a2, a3, a4}, we_a.size(), we_a[0], we_d[0], reg_addr);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_abort();
    test_reset_mid();
    tests++;
    if (both_cnt != 0) begin fails++; $display("FAIL we_re_overlap: got %0d want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
